// File: rtl/enc_scan.sv
// Sequential priority scanner: latches a request vector over a valid/ready
// handshake and emits the index of every set bit, one beat per handshake.
module enc_scan #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       en,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           din,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(WIDTH)-1:0]   dout_idx,
  output logic [WIDTH-1:0]           dout_onehot,
  output logic                       dout_last,
  output logic                       dout_zero
);

  localparam int IDX_W = $clog2(WIDTH);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  pending_q, pending_d;
  logic              zero_q, zero_d;

  logic [IDX_W-1:0]  sel_idx;
  logic              has_bit;
  logic              single_bit;
  logic              in_fire;
  logic              beat_fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      zero_q    <= zero_d;
    end
  end

  // The last assignment in scan order wins, so the loop direction sets priority.
  always_comb begin
    sel_idx = '0;
    if (MSB_FIRST) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (pending_q[i]) sel_idx = IDX_W'(i);
      end
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (pending_q[i]) sel_idx = IDX_W'(i);
      end
    end
  end

  assign has_bit    = |pending_q;
  assign single_bit = has_bit && ((pending_q & (pending_q - WIDTH'(1))) == '0);
  assign in_fire    = in_valid & in_ready;
  assign beat_fire  = out_valid & out_ready;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    zero_d    = zero_q;
    if (beat_fire) begin
      pending_d = pending_q & ~dout_onehot;
      if (dout_last) begin
        state_d = IDLE;
        zero_d  = 1'b0;
      end
    end
    // A reload on the final beat's edge overrides the return to IDLE.
    if (in_fire) begin
      pending_d = din;
      zero_d    = (din == '0);
      state_d   = SCAN;
    end
  end

  always_comb begin
    out_valid   = 1'b0;
    dout_idx    = '0;
    dout_onehot = '0;
    dout_last   = 1'b0;
    dout_zero   = 1'b0;
    if (state_q == SCAN) begin
      out_valid   = en;
      dout_idx    = sel_idx;
      dout_onehot = has_bit ? (WIDTH'(1) << sel_idx) : '0;
      dout_last   = zero_q | single_bit;
      dout_zero   = zero_q;
    end
    in_ready = en & ((state_q == IDLE) | (out_valid & out_ready & dout_last));
  end

endmodule
